// File: rtl/tcp_vlg_tx_gather.sv
// Transmit-side byte gatherer: buffers user bytes in a circular RAM, cuts them into
// segments (MSS, idle timeout or forced send) and streams each offered segment once.
module tcp_vlg_tx_gather #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned MSS        = 1460,
    parameter int unsigned WAIT_TICKS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        connected,
    input  logic [7:0]  in_dat,
    input  logic        in_val,
    input  logic        in_snd,
    output logic        in_cts,
    output logic        ovf,
    output logic        seg_rdy,
    output logic [15:0] seg_len,
    input  logic        seg_req,
    output logic [7:0]  seg_dat,
    output logic        seg_val,
    output logic        seg_last,
    input  logic        flush,
    output logic        flushed
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(WAIT_TICKS);

    typedef enum logic [1:0] {IDLE, READY, SEND, FLUSH} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nx;
    logic [TW-1:0]   timer;
    logic            snd_pend;
    logic [15:0]     send_cnt;
    logic            acc;
    logic            rd_go;
    logic            cut;
    logic [7:0]      rd_dat_p0;
    logic            vld_p0;
    logic            last_p0;

    // Idle timer stops at the cut threshold so leftover bytes are never stranded.
    function automatic logic [TW-1:0] timer_sat_inc(input logic [TW-1:0] t);
        if (32'(t) >= WAIT_TICKS - 1)
            return t;
        return t + TW'(1);
    endfunction

    function automatic logic [15:0] seg_min(input logic [CW-1:0] c);
        if (32'(c) >= MSS)
            return 16'(MSS);
        return 16'(c);
    endfunction

    always_comb begin
        acc   = in_val & connected & (32'(count) < DEPTH) & (state != FLUSH) & ~flush;
        rd_go = (state == SEND) & (send_cnt != seg_len) & ~flush;
        cut   = (count != '0) &
                ((32'(count) >= MSS) | (32'(timer) == WAIT_TICKS - 1) | snd_pend);
        count_nx = count;
        if (flush)
            count_nx = '0;
        else if (acc & ~rd_go)
            count_nx = count + CW'(1);
        else if (~acc & rd_go)
            count_nx = count - CW'(1);
    end

    // p0: RAM write and registered RAM read
    always_ff @(posedge clk) begin
        if (acc)
            mem[wr_ptr] <= in_dat;
        rd_dat_p0 <= mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            timer    <= '0;
            snd_pend <= 1'b0;
            send_cnt <= '0;
            vld_p0   <= 1'b0;
            last_p0  <= 1'b0;
            in_cts   <= 1'b0;
            ovf      <= 1'b0;
            seg_rdy  <= 1'b0;
            seg_len  <= '0;
            seg_dat  <= '0;
            seg_val  <= 1'b0;
            seg_last <= 1'b0;
            flushed  <= 1'b0;
        end else begin
            ovf     <= in_val & ~acc;
            flushed <= flush;
            in_cts  <= connected & ~flush & (32'(count_nx) < DEPTH - 1);
            count   <= count_nx;
            if (flush) begin
                state    <= FLUSH;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                timer    <= '0;
                snd_pend <= 1'b0;
                send_cnt <= '0;
                seg_rdy  <= 1'b0;
                vld_p0   <= 1'b0;
                last_p0  <= 1'b0;
                seg_val  <= 1'b0;
                seg_last <= 1'b0;
            end else begin
                if (acc)
                    wr_ptr <= wr_ptr + AW'(1);
                if (rd_go) begin
                    rd_ptr   <= rd_ptr + AW'(1);
                    send_cnt <= send_cnt + 16'd1;
                end
                if (acc || count == '0)
                    timer <= '0;
                else
                    timer <= timer_sat_inc(timer);

                if (in_snd && (count != '0 || acc))
                    snd_pend <= 1'b1;
                else if (state == IDLE && cut)
                    snd_pend <= 1'b0;

                vld_p0  <= rd_go;
                last_p0 <= rd_go & (send_cnt == seg_len - 16'd1);
                // p1: output register
                seg_val  <= vld_p0;
                seg_last <= vld_p0 & last_p0;
                if (vld_p0)
                    seg_dat <= rd_dat_p0;

                case (state)
                    IDLE: begin
                        if (cut) begin
                            state    <= READY;
                            seg_rdy  <= 1'b1;
                            seg_len  <= seg_min(count);
                            send_cnt <= '0;
                        end
                    end
                    READY: begin
                        if (seg_req) begin
                            state   <= SEND;
                            seg_rdy <= 1'b0;
                        end
                    end
                    SEND: begin
                        if (vld_p0 && last_p0)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tcp_vlg_tx_gather.sv
// Self-checking bench for tcp_vlg_tx_gather: directed corner cases plus a randomized
// run scored against a byte-queue model of the user stream.
module tb_tcp_vlg_tx_gather;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned MSS   = 4;
    localparam int unsigned WAIT  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        connected;
    logic [7:0]  in_dat;
    logic        in_val;
    logic        in_snd;
    logic        in_cts;
    logic        ovf;
    logic        seg_rdy;
    logic [15:0] seg_len;
    logic        seg_req;
    logic [7:0]  seg_dat;
    logic        seg_val;
    logic        seg_last;
    logic        flush;
    logic        flushed;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];

    tcp_vlg_tx_gather #(.DEPTH(DEPTH), .MSS(MSS), .WAIT_TICKS(WAIT)) dut (
        .clk(clk), .rst(rst), .connected(connected),
        .in_dat(in_dat), .in_val(in_val), .in_snd(in_snd), .in_cts(in_cts), .ovf(ovf),
        .seg_rdy(seg_rdy), .seg_len(seg_len), .seg_req(seg_req),
        .seg_dat(seg_dat), .seg_val(seg_val), .seg_last(seg_last),
        .flush(flush), .flushed(flushed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input bit keep);
        in_val = 1'b1;
        in_dat = b;
        if (keep) exp_q.push_back(b);
        tick();
        in_val = 1'b0;
    endtask

    task automatic wait_rdy();
        int k;
        k = 0;
        while (!seg_rdy && k < 100) begin
            tick();
            k++;
        end
        chk("seg_rdy_wait", seg_rdy, 1);
    endtask

    task automatic pop_chk(input string tag);
        if (exp_q.size() == 0)
            chk({tag, "_underflow"}, 0, 1);
        else
            chk(tag, seg_dat, exp_q.pop_front());
    endtask

    task automatic recv_seg(input int n);
        wait_rdy();
        chk("seg_len", seg_len, n);
        seg_req = 1'b1;
        tick();
        seg_req = 1'b0;
        chk("rdy_drop", seg_rdy, 0);
        chk("lat_val1", seg_val, 0);
        tick();
        chk("lat_val2", seg_val, 0);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk("seg_val", seg_val, 1);
            pop_chk("seg_dat");
            chk("seg_last", seg_last, (i == n));
        end
        tick();
        chk("val_end", seg_val, 0);
    endtask

    initial begin
        int  k;
        bit  seen;
        bit  req_now;
        bit  in_seg;
        int  idx;
        int  cur_len;
        bit  was_rdy;
        logic [15:0] prev_len;

        rst = 1'b1; connected = 1'b1; in_dat = '0; in_val = 1'b0; in_snd = 1'b0;
        seg_req = 1'b0; flush = 1'b0;
        tick(); tick(); tick();
        chk("rst_cts", in_cts, 0);   chk("rst_ovf", ovf, 0);
        chk("rst_rdy", seg_rdy, 0);  chk("rst_len", seg_len, 0);
        chk("rst_dat", seg_dat, 0);  chk("rst_val", seg_val, 0);
        chk("rst_last", seg_last, 0); chk("rst_flushed", flushed, 0);
        rst = 1'b0;
        tick();
        chk("cts_up", in_cts, 1);

        // full-MSS segment
        for (int i = 1; i <= 4; i++) put(8'(i), 1'b1);
        recv_seg(4);

        // idle-timeout cut
        for (int i = 0; i < 3; i++) put(8'h21 + 8'(i), 1'b1);
        k = 0;
        while (!seg_rdy && k < 40) begin
            tick();
            k++;
        end
        chk("idle_cut_delay", k, WAIT);
        recv_seg(3);

        // forced send, then forced send on empty buffer
        put(8'h31, 1'b1);
        put(8'h32, 1'b1);
        in_snd = 1'b1;
        tick();
        in_snd = 1'b0;
        k = 1;
        if (!seg_rdy) begin
            tick();
            k = 2;
        end
        chk("snd_cut", (seg_rdy && k <= 2), 1);
        recv_seg(2);
        in_snd = 1'b1;
        tick();
        in_snd = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            seen |= seg_rdy;
        end
        chk("snd_empty", seen, 0);

        // fill beyond capacity, then read back across pointer wrap
        for (int i = 1; i <= 20; i++) begin
            put(8'(i), (i <= 16));
            chk("fill_cts", in_cts, (i < 15));
            chk("fill_ovf", ovf, (i > 16));
        end
        tick();
        chk("ovf_clear", ovf, 0);
        for (int s = 0; s < 4; s++) recv_seg(4);

        // flush in the middle of a segment
        for (int i = 0; i < 4; i++) put(8'h41 + 8'(i), 1'b1);
        wait_rdy();
        chk("fl_len", seg_len, 4);
        seg_req = 1'b1;
        tick();
        seg_req = 1'b0;
        tick();
        tick();
        chk("fl_b1", seg_dat, 8'h41);
        tick();
        chk("fl_b2_val", seg_val, 1);
        chk("fl_b2", seg_dat, 8'h42);
        flush = 1'b1;
        tick();
        chk("fl_val0", seg_val, 0);
        chk("fl_last0", seg_last, 0);
        chk("fl_flushed", flushed, 1);
        chk("fl_rdy0", seg_rdy, 0);
        chk("fl_cts0", in_cts, 0);
        tick();
        chk("fl_val1", seg_val, 0);
        chk("fl_last1", seg_last, 0);
        chk("fl_flushed1", flushed, 1);
        flush = 1'b0;
        exp_q.delete();
        tick();
        chk("fl_done", flushed, 0);
        chk("fl_cts_up", in_cts, 1);
        for (int i = 0; i < 4; i++) put(8'h51 + 8'(i), 1'b1);
        recv_seg(4);

        // disconnect keeps buffered data; no writes while disconnected
        put(8'h61, 1'b1);
        put(8'h62, 1'b1);
        connected = 1'b0;
        tick();
        chk("dc_cts", in_cts, 0);
        recv_seg(2);
        in_val = 1'b1;
        in_dat = 8'h99;
        tick();
        in_val = 1'b0;
        chk("dc_ovf", ovf, 1);
        chk("dc_cts2", in_cts, 0);
        tick();
        chk("dc_ovf_clr", ovf, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen |= seg_rdy;
        end
        chk("dc_nowrite", seen, 0);
        connected = 1'b1;
        tick();

        // randomized traffic, then drain
        in_seg = 0; idx = 0; cur_len = 0; was_rdy = 0; prev_len = '0;
        for (int c = 0; c < 6000; c++) begin
            if (c >= 3000 && exp_q.size() == 0 && !in_seg) break;
            in_val  = (c < 3000) && in_cts && ($urandom_range(0, 3) != 0);
            in_dat  = 8'($urandom);
            in_snd  = (c < 3000) && ($urandom_range(0, 31) == 0);
            req_now = seg_rdy && ($urandom_range(0, 2) == 0);
            seg_req = req_now;
            if (seg_rdy && was_rdy) chk("rnd_len_stable", seg_len, prev_len);
            was_rdy  = seg_rdy;
            prev_len = seg_len;
            if (req_now) begin
                chk("rnd_len_ok", (seg_len >= 1 && seg_len <= MSS && seg_len <= exp_q.size()), 1);
                cur_len = seg_len;
                idx = 0;
                in_seg = 1;
                was_rdy = 0;
            end
            if (in_val) exp_q.push_back(in_dat);
            tick();
            in_val = 1'b0;
            in_snd = 1'b0;
            seg_req = 1'b0;
            chk("rnd_ovf", ovf, 0);
            if (seg_val) begin
                chk("rnd_in_seg", in_seg, 1);
                idx++;
                pop_chk("rnd_dat");
                chk("rnd_last", seg_last, (idx == cur_len));
                if (seg_last) in_seg = 0;
            end
        end
        chk("rnd_drain", exp_q.size(), 0);

        // reset in the middle of a segment
        for (int i = 0; i < 4; i++) put(8'h71 + 8'(i), 1'b1);
        wait_rdy();
        seg_req = 1'b1;
        tick();
        seg_req = 1'b0;
        tick();
        tick();
        chk("mr_val", seg_val, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_cts", in_cts, 0);   chk("mr_ovf", ovf, 0);
        chk("mr_rdy", seg_rdy, 0);  chk("mr_len", seg_len, 0);
        chk("mr_dat", seg_dat, 0);  chk("mr_val0", seg_val, 0);
        chk("mr_last", seg_last, 0); chk("mr_flushed", flushed, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        chk("mr_cts_up", in_cts, 1);
        chk("mr_rdy_after", seg_rdy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
